// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receive control slice.
//   idle_state_t       : idle-gap FSM state encoding
//   OVERSAMPLE         : receiver oversampling ratio (s_ticks per bit)
//   IDLE_TICKS_DEFAULT : default idle gap, ten bit-times of s_ticks
package uart_pkg;

    localparam int OVERSAMPLE         = 16;
    localparam int IDLE_TICKS_DEFAULT = OVERSAMPLE * 10;

    typedef enum logic {
        DISARMED = 1'b0,
        ARMED    = 1'b1
    } idle_state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: programmable oversample tick generator.
//   clk      in  system clock
//   reset_n  in  asynchronous active-low reset
//   enable   in  1 = count; 0 = counter held at 0, no ticks
//   baud_div in  tick period minus 1, in clk cycles
//   s_tick   out registered one-cycle tick
module uart_baud_gen #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [DIV_W-1:0] baud_div,
    output logic             s_tick
);

    logic [DIV_W-1:0] div_cnt;

    // ">=" rather than "==" so that lowering baud_div below the current
    // count wraps on the next cycle instead of running through 2^DIV_W.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
            s_tick  <= 1'b0;
        end else if (!enable) begin
            div_cnt <= '0;
            s_tick  <= 1'b0;
        end else if (div_cnt >= baud_div) begin
            div_cnt <= '0;
            s_tick  <= 1'b1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
            s_tick  <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: control wrapper for an 8N1 16x-oversampling UART receiver.
// Generates the receiver tick, buffers received bytes in a FIFO read through
// a valid/ready port, flags overrun and pulses rx_idle after a quiet gap.
//   clk, reset_n          clock, asynchronous active-low reset
//   enable                tick generation and byte capture active
//   baud_div              s_tick period minus 1
//   s_tick                oversample tick to the receiver
//   rx_done_tick, rx_data byte-complete pulse and byte from the receiver
//   m_valid/m_data/m_ready FIFO head, popped on valid && ready
//   fifo_count            occupancy 0..FIFO_DEPTH
//   overrun, clr_overrun  sticky drop flag and its clear
//   rx_idle               one-cycle pulse after IDLE_TICKS quiet s_ticks
//   byte_cnt, drop_cnt    saturating statistics (UART_RX_CTRL_STATS_EN)
// Build option: define UART_RX_CTRL_STATS_EN to enable the statistic
// counters; otherwise byte_cnt/drop_cnt read 0.
//
// Idle FSM states:
//   state    | meaning
//   DISARMED | no byte since the last idle pulse / reset / disable
//   ARMED    | byte seen, counting s_ticks towards IDLE_TICKS
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int IDLE_TICKS = IDLE_TICKS_DEFAULT
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        enable,
    input  logic [DIV_W-1:0]            baud_div,
    output logic                        s_tick,
    input  logic                        rx_done_tick,
    input  logic [7:0]                  rx_data,
    output logic                        m_valid,
    output logic [7:0]                  m_data,
    input  logic                        m_ready,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        overrun,
    input  logic                        clr_overrun,
    output logic                        rx_idle,
    output logic [15:0]                 byte_cnt,
    output logic [15:0]                 drop_cnt
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int IDLE_W = $clog2(IDLE_TICKS + 1);

    uart_baud_gen #(.DIV_W(DIV_W)) u_baud_gen (
        .clk      (clk),
        .reset_n  (reset_n),
        .enable   (enable),
        .baud_div (baud_div),
        .s_tick   (s_tick)
    );

    // ---------------- FIFO ----------------
    logic [7:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push_req, push, pop, drop, full;

    assign push_req = rx_done_tick & enable;
    assign pop      = m_valid & m_ready;
    assign full     = (count == CNT_W'(FIFO_DEPTH));
    // A simultaneous pop frees the slot, so a full FIFO still accepts.
    assign push     = push_req & (~full | pop);
    assign drop     = push_req & full & ~pop;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop)             overrun <= 1'b1;
            else if (clr_overrun) overrun <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= rx_data;
    end

    assign m_valid    = (count != '0);
    assign m_data     = m_valid ? mem[rd_ptr] : 8'h00;
    assign fifo_count = count;

    // ---------------- Idle FSM ----------------
    idle_state_t       state, state_nxt;
    logic [IDLE_W-1:0] idle_cnt, idle_cnt_nxt;
    logic              gap_done;

    assign gap_done = (idle_cnt == IDLE_W'(IDLE_TICKS));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= DISARMED;
            idle_cnt <= '0;
        end else begin
            state    <= state_nxt;
            idle_cnt <= idle_cnt_nxt;
        end
    end

    // Any receiver byte re-arms, including one dropped on a full FIFO:
    // the line was still active.
    always_comb begin
        state_nxt    = state;
        idle_cnt_nxt = idle_cnt;
        if (!enable) begin
            state_nxt    = DISARMED;
            idle_cnt_nxt = '0;
        end else begin
            case (state)
                DISARMED: begin
                    if (push_req) begin
                        state_nxt    = ARMED;
                        idle_cnt_nxt = '0;
                    end
                end
                ARMED: begin
                    if (push_req) begin
                        idle_cnt_nxt = '0;
                    end else if (gap_done) begin
                        state_nxt    = DISARMED;
                        idle_cnt_nxt = '0;
                    end else if (s_tick) begin
                        idle_cnt_nxt = idle_cnt + 1'b1;
                    end
                end
                default: begin
                    state_nxt    = DISARMED;
                    idle_cnt_nxt = '0;
                end
            endcase
        end
    end

    always_comb begin
        rx_idle = 1'b0;
        if (state == ARMED && enable && gap_done) rx_idle = 1'b1;
    end

    // ---------------- Statistics ----------------
`ifdef UART_RX_CTRL_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            byte_cnt <= '0;
            drop_cnt <= '0;
        end else begin
            if (push && byte_cnt != 16'hFFFF) byte_cnt <= byte_cnt + 1'b1;
            if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
        end
    end
`else
    assign byte_cnt = 16'h0000;
    assign drop_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
module tb_uart_rx_ctrl;

    localparam int DEPTH = 8;
    localparam int IDLE  = 160;
`ifdef UART_RX_CTRL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        enable = 1'b0;
    logic [15:0] baud_div = 16'd0;
    logic        s_tick;
    logic        rx_done_tick = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        m_valid;
    logic [7:0]  m_data;
    logic        m_ready = 1'b0;
    logic [3:0]  fifo_count;
    logic        overrun;
    logic        clr_overrun = 1'b0;
    logic        rx_idle;
    logic [15:0] byte_cnt;
    logic [15:0] drop_cnt;

    uart_rx_ctrl dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .enable       (enable),
        .baud_div     (baud_div),
        .s_tick       (s_tick),
        .rx_done_tick (rx_done_tick),
        .rx_data      (rx_data),
        .m_valid      (m_valid),
        .m_data       (m_data),
        .m_ready      (m_ready),
        .fifo_count   (fifo_count),
        .overrun      (overrun),
        .clr_overrun  (clr_overrun),
        .rx_idle      (rx_idle),
        .byte_cnt     (byte_cnt),
        .drop_cnt     (drop_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    function automatic void chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: actual=0x%0h required=0x%0h", name, $time, act, exp);
        end
    endfunction

    // Reference model: byte queue, sticky flag, statistics, idle gap tracker.
    logic [7:0] exp_q[$];
    bit         exp_ovr = 1'b0;
    int         exp_bytes = 0;
    int         exp_drops = 0;
    bit         gap_pending = 1'b0;
    int         gap_ticks = 0;
    int         idle_q[$];
    int         cyc = 0;

    always @(negedge clk) begin
        if (!reset_n) begin
            chk("rst_m_valid", int'(m_valid), 0);
            chk("rst_fifo_count", int'(fifo_count), 0);
            chk("rst_overrun", int'(overrun), 0);
            chk("rst_rx_idle", int'(rx_idle), 0);
            chk("rst_s_tick", int'(s_tick), 0);
            chk("rst_m_data", int'(m_data), 0);
            chk("rst_stats", int'(byte_cnt) + int'(drop_cnt), 0);
            exp_q.delete();
            idle_q.delete();
            exp_ovr = 1'b0;
            exp_bytes = 0;
            exp_drops = 0;
            gap_pending = 1'b0;
            gap_ticks = 0;
        end else begin
            bit do_pop, do_push, do_drop;
            chk("m_valid", int'(m_valid), int'(exp_q.size() != 0));
            chk("fifo_count", int'(fifo_count), exp_q.size());
            chk("overrun", int'(overrun), int'(exp_ovr));
            chk("byte_cnt", int'(byte_cnt), STATS ? exp_bytes : 0);
            chk("drop_cnt", int'(drop_cnt), STATS ? exp_drops : 0);
            if (exp_q.size() == 0) chk("m_data_empty", int'(m_data), 0);

            while (idle_q.size() != 0 && idle_q[0] < cyc) begin
                chk("idle_missed_cycle", -1, idle_q[0]);
                void'(idle_q.pop_front());
            end
            if (rx_idle) begin
                if (idle_q.size() == 0) chk("idle_unexpected_cycle", cyc, -1);
                else chk("idle_cycle", cyc, idle_q.pop_front());
            end

            // Predict the effect of the coming clock edge.
            do_pop  = (exp_q.size() != 0) && m_ready;
            do_push = rx_done_tick && enable;
            do_drop = do_push && (exp_q.size() == DEPTH) && !do_pop;
            if (do_pop) begin
                chk("pop_data", int'(m_data), int'(exp_q[0]));
                void'(exp_q.pop_front());
            end
            if (do_push && !do_drop) begin
                exp_q.push_back(rx_data);
                if (exp_bytes < 65535) exp_bytes++;
            end
            if (do_drop) begin
                exp_ovr = 1'b1;
                if (exp_drops < 65535) exp_drops++;
            end else if (clr_overrun) begin
                exp_ovr = 1'b0;
            end

            if (!enable) begin
                gap_pending = 1'b0;
            end else if (do_push) begin
                gap_pending = 1'b1;
                gap_ticks = 0;
            end else if (gap_pending && s_tick) begin
                gap_ticks++;
                if (gap_ticks == IDLE) begin
                    idle_q.push_back(cyc + 1);
                    gap_pending = 1'b0;
                end
            end
        end
        cyc++;
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        rx_done_tick = 1'b1;
        rx_data = b;
        next_cycle();
        rx_done_tick = 1'b0;
    endtask

    // Negedges after a fresh enable until the tick pattern for period 4.
    task automatic check_div3_pattern(input string name);
        for (int i = 0; i <= 12; i++) begin
            @(negedge clk);
            chk(name, int'(s_tick), int'(i > 0 && i % 4 == 0));
        end
    endtask

    // Negedges from now until rx_idle; -1 when the bound expires.
    task automatic measure_idle(output int k);
        k = -1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (rx_idle) begin
                k = i;
                break;
            end
        end
    endtask

    task automatic count_idle(input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (rx_idle) pulses++;
        end
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, pulses;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        next_cycle();

        // 1: tick generator period and enable behaviour
        baud_div = 16'd3;
        enable = 1'b1;
        check_div3_pattern("tick_div3");
        next_cycle();
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("tick_disabled", int'(s_tick), 0);
        end
        next_cycle();
        enable = 1'b1;
        check_div3_pattern("tick_reenable");
        next_cycle();

        // 2: basic push / pop ordering, no fall-through
        chk("t2_empty", int'(m_valid), 0);
        push_byte(8'hA5);
        chk("t2_valid_after_push", int'(m_valid), 1);
        chk("t2_head", int'(m_data), 'hA5);
        push_byte(8'h3C);
        chk("t2_count", int'(fifo_count), 2);
        m_ready = 1'b1;
        next_cycle();
        chk("t2_second", int'(m_data), 'h3C);
        next_cycle();
        chk("t2_drained", int'(m_valid), 0);
        m_ready = 1'b0;

        // 3: overrun on the ninth byte, drain order, clear
        for (int i = 1; i <= 9; i++) push_byte(8'(i));
        chk("t3_count_full", int'(fifo_count), 8);
        chk("t3_overrun", int'(overrun), 1);
        chk("t3_drop_cnt", int'(drop_cnt), STATS ? 1 : 0);
        m_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            chk("t3_drain", int'(m_data), i);
            next_cycle();
        end
        m_ready = 1'b0;
        chk("t3_empty", int'(m_valid), 0);
        clr_overrun = 1'b1;
        next_cycle();
        clr_overrun = 1'b0;
        chk("t3_cleared", int'(overrun), 0);

        // drop and clear together: drop wins
        for (int i = 0; i < 8; i++) push_byte(8'(8'h10 + i));
        clr_overrun = 1'b1;
        push_byte(8'hEE);
        clr_overrun = 1'b0;
        chk("t3_drop_beats_clear", int'(overrun), 1);
        clr_overrun = 1'b1;
        next_cycle();
        clr_overrun = 1'b0;

        // 4: full FIFO, push and pop in the same cycle
        m_ready = 1'b1;
        push_byte(8'h55);
        m_ready = 1'b0;
        chk("t4_no_overrun", int'(overrun), 0);
        chk("t4_count", int'(fifo_count), 8);
        m_ready = 1'b1;
        for (int i = 1; i < 8; i++) begin
            chk("t4_drain", int'(m_data), 'h10 + i);
            next_cycle();
        end
        chk("t4_last", int'(m_data), 'h55);
        next_cycle();
        m_ready = 1'b0;

        // 5: idle gap with s_tick every cycle
        baud_div = 16'd0;
        repeat (700) next_cycle();
        push_byte(8'h61);
        measure_idle(k);
        chk("t5_idle_delay", k, IDLE);
        push_byte(8'h62);
        repeat (99) next_cycle();
        push_byte(8'h63);
        measure_idle(k);
        chk("t5_retrigger_delay", k, IDLE);
        count_idle(400, pulses);
        chk("t5_no_push_no_pulse", pulses, 0);
        m_ready = 1'b1;
        repeat (4) next_cycle();
        m_ready = 1'b0;

        // randomized traffic, including quiet gaps
        for (int r = 0; r < 4; r++) begin
            baud_div = 16'($urandom_range(0, 1));
            for (int i = 0; i < 300; i++) begin
                rx_done_tick = ($urandom_range(0, 3) == 0);
                rx_data = 8'($urandom);
                m_ready = ($urandom_range(0, 2) == 0);
                clr_overrun = ($urandom_range(0, 15) == 0);
                next_cycle();
            end
            rx_done_tick = 1'b0;
            clr_overrun = 1'b0;
            m_ready = 1'b1;
            repeat (400) next_cycle();
            m_ready = 1'b0;
        end

        // 6: asynchronous reset with bytes queued and the FSM armed
        baud_div = 16'd0;
        for (int i = 0; i < 5; i++) push_byte(8'(8'hC0 + i));
        repeat (10) next_cycle();
        chk("t6_queued", int'(fifo_count), 5);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t6_async_valid", int'(m_valid), 0);
        chk("t6_async_count", int'(fifo_count), 0);
        chk("t6_async_overrun", int'(overrun), 0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        count_idle(400, pulses);
        chk("t6_no_idle_after_reset", pulses, 0);

        next_cycle();
        chk("end_idle_outstanding", idle_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Control block around the 8N1 16x-oversampling UART receiver.
- Generates the receiver's s_tick from a programmable divider.
- Buffers each completed byte (rx_done_tick/dout) in a small FIFO drained through a valid/ready interface.
- Flags FIFO overrun.
- Signals a line-idle gap so downstream logic can frame messages.

Parameters:
DIV_W, 16, width of baud divisor.
FIFO_DEPTH, 8, byte entries; power of 2, minimum 2.
IDLE_TICKS, 160, s_ticks without a new byte before rx_idle fires (10 bit-times at 16x).

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
enable  in  1  1 = tick generation and byte capture active
baud_div  in  DIV_W  s_tick period minus 1, in clk cycles
s_tick  out  1  oversample tick to receiver
rx_done_tick  in  1  receiver byte-complete pulse
rx_data  in  8  receiver dout, valid with rx_done_tick
m_valid  out  1  FIFO head byte available
m_data  out  8  FIFO head byte
m_ready  in  1  consumer accepts head
fifo_count  out  $clog2(FIFO_DEPTH)+1  occupancy
overrun  out  1  sticky: byte dropped on full FIFO
clr_overrun  in  1  clears overrun
rx_idle  out  1  one-cycle idle-gap pulse
byte_cnt  out  16  received-byte statistic (see Optional Feature)
drop_cnt  out  16  dropped-byte statistic (see Optional Feature)

Behaviour:
Reset:
- All outputs 0.
- Divider counter 0, FIFO empty, idle FSM DISARMED.

Tick generator:
- div_cnt increments each clk while enable=1.
- When div_cnt >= baud_div: s_tick=1 for one cycle and div_cnt returns to 0.
- Consequences: baud_div=0 gives s_tick every cycle; lowering baud_div mid-count wraps on the next cycle.
- enable=0: div_cnt forced to 0, s_tick=0.

Capture:
- rx_done_tick with enable=1 is a push; with enable=0 it is ignored.
- Pop occurs when m_valid && m_ready.
- m_valid = (count != 0). m_data = mem[rd_ptr], stable while m_valid && !m_ready.
- No fall-through: a push into an empty FIFO raises m_valid the next cycle.
- Push + pop in the same cycle: count unchanged, both pointers advance.
- Full with push and no pop: byte dropped, pointers/count unchanged, overrun set.
- Full with push and pop together: push accepted, no overrun.
- Pointers wrap modulo FIFO_DEPTH. count ranges 0..FIFO_DEPTH.
- clr_overrun clears overrun; a drop in the same cycle wins (overrun stays 1).

Idle FSM:
- Counts s_ticks; the counter saturates at IDLE_TICKS.
- DISARMED: on push -> ARMED, counter 0.
- ARMED: each s_tick increments the counter; any push resets it to 0.
  - Counter reaches IDLE_TICKS -> rx_idle=1 for one cycle -> DISARMED.
- Exactly one rx_idle per gap, and only after at least one byte.
- enable=0 in ARMED -> DISARMED, counter 0, no pulse.

Reset mid-operation (asynchronous):
- FIFO contents discarded; outputs return to reset values immediately.

Optional Feature:
Macro: UART_RX_CTRL_STATS_EN
- Defined:
  - byte_cnt increments on every accepted push.
  - drop_cnt increments on every dropped byte.
  - Both are 16-bit, saturate at 0xFFFF, cleared only by reset.
- Undefined: byte_cnt and drop_cnt tied to 0; no counter flops.

Decomposition:
Package uart_pkg holds:
- Idle FSM state encoding (DISARMED=1'b0, ARMED=1'b1).
- OVERSAMPLE=16.
- Default IDLE_TICKS derivation (OVERSAMPLE*10).

Sub-module uart_baud_gen holds the divider (clk, reset_n, enable, baud_div -> s_tick). FIFO and idle FSM stay inline.

Test Plan:
1. baud_div=3, enable=1 -> s_tick every 4th clk; enable=0 for 5 cycles -> no s_tick; after re-enable the first s_tick comes 4 clks later.
2. Push 0xA5 then 0x3C with m_ready=0 -> m_valid one cycle after first push, m_data=0xA5, fifo_count=2; m_ready=1 -> pop order 0xA5, 0x3C, then m_valid=0.
3. Push 9 bytes 0x01..0x09 with FIFO_DEPTH=8, m_ready=0 -> fifo_count=8, overrun=1, drop_cnt=1 (STATS_EN); drain yields 0x01..0x08; clr_overrun -> overrun=0.
4. FIFO full, push 0x55 and pop in the same cycle -> overrun stays 0, fifo_count stays 8, 0x55 read last.
5. IDLE_TICKS=160, baud_div=0: one push then no activity -> rx_idle pulses exactly once 160 s_ticks later. A second push at tick 100 -> pulse 160 ticks after that push. No push -> no pulse.
6. Assert reset_n low with 5 bytes queued and ARMED -> m_valid=0, fifo_count=0, overrun=0, and no rx_idle after release.
